shift_reg_seq: RTL and testbench
================================

# shift_reg_seq

Parametrised, counted successor to the 8-bit load/shift-right register. It has a configurable width, eight shift/rotate/serial modes, a serial input and output, and a programmable shift count with busy/done handshake. A count of zero gives free-running behaviour identical to the legacy block. It sits between parallel bus logic and serial/bit-stream consumers such as serialisers and bit-level datapaths.

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2)
- CNT_W, 4, width of shift-count input; max counted shifts = 2^CNT_W−1

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- load  in  1  parallel load and start strobe
- d_in  in  WIDTH  parallel load data
- mode  in  3  operation, latched at load
- count  in  CNT_W  shifts to perform, latched at load; 0 = free-run
- ser_in  in  1  serial fill bit for modes 3/4
- d_out  out  WIDTH  register contents
- ser_out  out  1  bit expelled by the most recent shift
- busy  out  1  shifting in progress
- done  out  1  one-cycle completion pulse

## Operation
- Priority per edge: reset > load > shift.
- Reset values: d_out=0, ser_out=0, busy=0, done=0, state IDLE, remaining count=0, latched mode=0.
- Load: d_out←d_in, ser_out←0, mode_r←mode, rem←count, done←0, busy←1.
  - count≠0 → SHIFT.
  - count=0 → FREE.
- Modes (mode_r), applied to d_out each shift edge:
  - 0: LSR, MSB←0, ser_out←d[0].
  - 1: LSL, LSB←0, ser_out←d[W−1].
  - 2: ASR, MSB←d[W−1], ser_out←d[0].
  - 3: serial right, MSB←ser_in, ser_out←d[0].
  - 4: serial left, LSB←ser_in, ser_out←d[W−1].
  - 5: ROR, MSB←d[0], ser_out←d[0].
  - 6: ROL, LSB←d[W−1], ser_out←d[W−1].
  - 7: hold. d_out and ser_out unchanged; still counts.
- States:
  - IDLE: d_out and ser_out hold; busy=0.
  - SHIFT: one op per edge, rem decrements. On the edge where rem=1, perform the final op, then → IDLE with busy←0 and done←1.
  - FREE: one op per edge indefinitely, busy=1, done never asserts. Leaves only on load or reset.
- done is high for exactly one cycle, then clears on the next edge unless reset or load occurs.
- Load during SHIFT/FREE aborts the current operation with no done pulse, and the new operation starts from d_in.
- Reset mid-operation returns all outputs to reset values on that edge. No done pulse.
- Count is unsigned; no wrap. Shifts beyond WIDTH keep shifting, e.g. LSR reaches all-zero.

## Timing
- Load sampled at edge L; d_out=d_in after L.
- First shift at edge L+1.
- With count N>0, shifts occur at edges L+1..L+N. busy is high after L through L+N−1 and low after L+N.
- done is high for the cycle after edge L+N only.
- ser_in is sampled at each shift edge.
- Zero combinational paths from inputs to outputs; all outputs are registered.
- Load asserted the cycle done is high: done falls at that edge and the new operation starts normally.

## Configuration
- ROTATE_EN defined: modes 5/6 rotate as specified.
- ROTATE_EN undefined: modes 5/6 behave exactly as mode 7 (hold, count still runs, done still pulses). Rotate logic is absent from the netlist.

## Test plan
- Reset for 1 cycle with load=1, d_in=0xFF → d_out=0x00, busy=0, done=0, ser_out=0 (reset beats load).
- Load 0xCC, mode 0, count 0 (legacy) → 0xCC after load; 0x66 after 1 edge; 0x00 after 8 edges; busy stays 1, done never asserts.
- Load 0xCC, mode 2, count 3 → 0xE6, 0xF3, 0xF9 on successive edges; ser_out=0,0,1; done=1 for one cycle after edge 3; busy=0 from then.
- Load 0x00, mode 4, count 4, ser_in=1 → d_out=0x0F, ser_out=0, one done pulse.
- Load 0x81, mode 5, count 1 → 0xC0 and ser_out=1 with ROTATE_EN; 0x81 and ser_out=0 without; done pulses in both builds.
- Abort cases:
  - Load 0xF0, mode 0, count 8. After 2 shifts (0x3C), load 0xAA, mode 1, count 1 → no done for the first operation; 0x54 next edge, then done.
  - Reset mid-count → all outputs 0, no done.

Source files
------------

// File: rtl/shift_reg_seq_if.sv
// Parallel/serial bus for shift_reg_seq: load strobe, operands, serial fill bit and
// the registered outputs (contents, expelled bit, busy/done handshake).
interface shift_reg_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             load;
    logic [WIDTH-1:0] d_in;
    logic [2:0]       mode;
    logic [CNT_W-1:0] count;
    logic             ser_in;
    logic [WIDTH-1:0] d_out;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output load, d_in, mode, count, ser_in,
        input  d_out, ser_out, busy, done
    );

    modport slave (
        input  load, d_in, mode, count, ser_in,
        output d_out, ser_out, busy, done
    );
endinterface

// File: rtl/shift_reg_seq.sv
// Counted load/shift/rotate register with busy/done handshake; count 0 free-runs.
// Define ROTATE_EN to build modes 5/6 as rotates; otherwise they hold like mode 7.
module shift_reg_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic           clock,
    input  logic           reset,
    shift_reg_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FREE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] data, data_nxt;
    logic             ser, ser_nxt;
    logic [2:0]       mode_r, mode_nxt;
    logic [CNT_W-1:0] rem, rem_nxt;
    logic             busy, busy_nxt;
    logic             done, done_nxt;

    logic [WIDTH-1:0] op_data;
    logic             op_ser;

    // Result of one shift of the current contents under the latched mode.
    always_comb begin
        op_data = data;
        op_ser  = ser;
        case (mode_r)
            3'd0: begin
                op_data = {1'b0, data[WIDTH-1:1]};
                op_ser  = data[0];
            end
            3'd1: begin
                op_data = {data[WIDTH-2:0], 1'b0};
                op_ser  = data[WIDTH-1];
            end
            3'd2: begin
                op_data = {data[WIDTH-1], data[WIDTH-1:1]};
                op_ser  = data[0];
            end
            3'd3: begin
                op_data = {bus.ser_in, data[WIDTH-1:1]};
                op_ser  = data[0];
            end
            3'd4: begin
                op_data = {data[WIDTH-2:0], bus.ser_in};
                op_ser  = data[WIDTH-1];
            end
`ifdef ROTATE_EN
            3'd5: begin
                op_data = {data[0], data[WIDTH-1:1]};
                op_ser  = data[0];
            end
            3'd6: begin
                op_data = {data[WIDTH-2:0], data[WIDTH-1]};
                op_ser  = data[WIDTH-1];
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_nxt = state;
        data_nxt  = data;
        ser_nxt   = ser;
        mode_nxt  = mode_r;
        rem_nxt   = rem;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        if (bus.load) begin
            data_nxt  = bus.d_in;
            ser_nxt   = 1'b0;
            mode_nxt  = bus.mode;
            rem_nxt   = bus.count;
            busy_nxt  = 1'b1;
            state_nxt = (bus.count != '0) ? SHIFT : FREE;
        end else begin
            case (state)
                SHIFT: begin
                    data_nxt = op_data;
                    ser_nxt  = op_ser;
                    rem_nxt  = rem - 1'b1;
                    if (rem == CNT_W'(1)) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
                FREE: begin
                    data_nxt = op_data;
                    ser_nxt  = op_ser;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            data   <= '0;
            ser    <= 1'b0;
            mode_r <= 3'd0;
            rem    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            data   <= data_nxt;
            ser    <= ser_nxt;
            mode_r <= mode_nxt;
            rem    <= rem_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    assign bus.d_out   = data;
    assign bus.ser_out = ser;
    assign bus.busy    = busy;
    assign bus.done    = done;
endmodule

// File: tb/tb_shift_reg_seq.sv
// Self-checking bench for shift_reg_seq: directed scenarios plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_shift_reg_seq;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam longint FULL = 64'd1 << WIDTH;
    localparam longint HALF = 64'd1 << (WIDTH - 1);

    logic clock = 1'b0;
    logic reset = 1'b1;

    shift_reg_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_reg_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: value as a plain integer, ops left as a counter.
    longint m_val;
    int     m_ser, m_busy, m_done, m_mode, m_left, m_free;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rotate_built();
`ifdef ROTATE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_shift(input int sin);
        longint lo = m_val % 2;
        longint hi = m_val / HALF;
        case (m_mode)
            0: begin m_ser = int'(lo); m_val = m_val / 2; end
            1: begin m_ser = int'(hi); m_val = (m_val * 2) % FULL; end
            2: begin m_ser = int'(lo); m_val = m_val / 2 + hi * HALF; end
            3: begin m_ser = int'(lo); m_val = m_val / 2 + sin * HALF; end
            4: begin m_ser = int'(hi); m_val = (m_val * 2) % FULL + sin; end
            5: if (rotate_built()) begin m_ser = int'(lo); m_val = m_val / 2 + lo * HALF; end
            6: if (rotate_built()) begin m_ser = int'(hi); m_val = (m_val * 2) % FULL + hi; end
            default: ;
        endcase
    endtask

    task automatic model_edge(input bit r, input bit l, input int d, input int m,
                              input int c, input int sin);
        if (r) begin
            m_val = 0; m_ser = 0; m_busy = 0; m_done = 0; m_mode = 0; m_left = 0; m_free = 0;
        end else if (l) begin
            m_val = d; m_ser = 0; m_mode = m; m_left = c; m_done = 0; m_busy = 1;
            m_free = (c == 0);
        end else if (m_busy != 0) begin
            model_shift(sin);
            m_done = 0;
            if (m_free == 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else begin
            m_done = 0;
        end
    endtask

    // Drive inputs on the falling edge, let one rising edge happen, then compare.
    task automatic tick(input bit r, input bit l, input int d, input int m,
                        input int c, input int sin);
        @(negedge clock);
        reset      = r;
        bus.load   = l;
        bus.d_in   = WIDTH'(d);
        bus.mode   = 3'(m);
        bus.count  = CNT_W'(c);
        bus.ser_in = sin[0];
        @(posedge clock);
        #1;
        model_edge(r, l, d, m, c, sin);
        check("d_out",   longint'(bus.d_out),   m_val);
        check("ser_out", longint'(bus.ser_out), longint'(m_ser));
        check("busy",    longint'(bus.busy),    longint'(m_busy));
        check("done",    longint'(bus.done),    longint'(m_done));
    endtask

    task automatic idle(input int sin = 0);
        tick(0, 0, 0, 0, 0, sin);
    endtask

    int done_seen;

    initial begin
        bus.load = 1'b0; bus.d_in = '0; bus.mode = '0; bus.count = '0; bus.ser_in = 1'b0;
        m_val = 0; m_ser = 0; m_busy = 0; m_done = 0; m_mode = 0; m_left = 0; m_free = 0;

        // Reset beats load.
        tick(1, 1, 'hFF, 0, 0, 0);
        check("rst_dout", longint'(bus.d_out), 0);
        check("rst_busy", longint'(bus.busy), 0);

        // Legacy free-run LSR.
        tick(0, 1, 'hCC, 0, 0, 0);
        check("free_load", longint'(bus.d_out), 'hCC);
        idle();
        check("free_1", longint'(bus.d_out), 'h66);
        done_seen = 0;
        for (int i = 0; i < 7; i++) begin
            idle();
            done_seen += bus.done;
        end
        check("free_8", longint'(bus.d_out), 0);
        check("free_busy", longint'(bus.busy), 1);
        check("free_nodone", longint'(done_seen), 0);

        // Counted ASR of 3.
        tick(0, 1, 'hCC, 2, 3, 0);
        idle(); check("asr_1", longint'(bus.d_out), 'hE6); check("asr_s1", longint'(bus.ser_out), 0);
        idle(); check("asr_2", longint'(bus.d_out), 'hF3); check("asr_s2", longint'(bus.ser_out), 0);
        idle(); check("asr_3", longint'(bus.d_out), 'hF9); check("asr_s3", longint'(bus.ser_out), 1);
        check("asr_done", longint'(bus.done), 1);
        check("asr_busy", longint'(bus.busy), 0);
        idle(); check("asr_done_clr", longint'(bus.done), 0);

        // Serial left fill with ones.
        tick(0, 1, 'h00, 4, 4, 1);
        for (int i = 0; i < 4; i++) idle(1);
        check("serl_val", longint'(bus.d_out), 'h0F);
        check("serl_done", longint'(bus.done), 1);
        idle();

        // Rotate right once (hold when rotate is not built).
        tick(0, 1, 'h81, 5, 1, 0);
        idle();
        check("ror_val", longint'(bus.d_out), rotate_built() ? 'hC0 : 'h81);
        check("ror_ser", longint'(bus.ser_out), rotate_built() ? 1 : 0);
        check("ror_done", longint'(bus.done), 1);

        // Load during done pulse, then abort by reload.
        tick(0, 1, 'hF0, 0, 8, 0);
        check("ld_on_done", longint'(bus.done), 0);
        idle(); idle();
        check("abort_mid", longint'(bus.d_out), 'h3C);
        tick(0, 1, 'hAA, 1, 1, 0);
        check("abort_nodone", longint'(bus.done), 0);
        idle();
        check("abort_new", longint'(bus.d_out), 'h54);
        check("abort_done", longint'(bus.done), 1);

        // Reset mid-count.
        tick(0, 1, 'hFF, 0, 10, 0);
        idle(); idle(); idle();
        tick(1, 0, 0, 0, 0, 0);
        check("rst_mid_dout", longint'(bus.d_out), 0);
        check("rst_mid_done", longint'(bus.done), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                 int'($urandom_range(255)), int'($urandom_range(7)),
                 int'($urandom_range(15)), int'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
